ram_init_seq: RTL and testbench



---
 rtl/ram_init_seq.sv | 160 ++++++++++++++++
 tb/tb_ram_init_seq.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/ram_init_seq.sv
// SDRAM power-up sequencer followed by a free-running periodic refresh
// requester with a req/ack handshake toward the memory controller core.
//
// state     | meaning
// ----------+---------------------------------------------------------
// WAIT_PWR  | power-up wait after reset, cke low, NOPs
// WAIT_RP   | PRECHARGE-all issued, waiting tRP
// WAIT_RFC1 | first AUTO REFRESH issued, waiting tRFC
// WAIT_RFC2 | second AUTO REFRESH issued, waiting tRFC
// WAIT_MRD  | LOAD MODE issued, waiting tMRD
// RUN       | init_done high, periodic refresh requests
module ram_init_seq #(
    parameter int unsigned PWR_WAIT     = 20000,
    parameter int unsigned T_RP         = 2,
    parameter int unsigned T_RFC        = 7,
    parameter int unsigned T_MRD        = 2,
    parameter int unsigned REF_INTERVAL = 780,
    parameter logic [12:0] MODE_VAL     = 13'h0022
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        cke,
    output logic [2:0]  cmd,
    output logic [12:0] addr,
    output logic        init_done,
    output logic        ref_req,
    input  logic        ref_ack,
    output logic        ref_miss
);

    localparam logic [2:0] CMD_NOP   = 3'b111;
    localparam logic [2:0] CMD_PRE   = 3'b010;
    localparam logic [2:0] CMD_AREF  = 3'b001;
    localparam logic [2:0] CMD_LMR   = 3'b000;

    localparam logic [15:0] CNT_PWR = 16'(PWR_WAIT);
    localparam logic [15:0] CNT_RP  = 16'(T_RP);
    localparam logic [15:0] CNT_RFC = 16'(T_RFC);
    localparam logic [15:0] CNT_MRD = 16'(T_MRD);
    localparam logic [15:0] CNT_REF = 16'(REF_INTERVAL);

    typedef enum logic [2:0] {
        WAIT_PWR  = 3'd0,
        WAIT_RP   = 3'd1,
        WAIT_RFC1 = 3'd2,
        WAIT_RFC2 = 3'd3,
        WAIT_MRD  = 3'd4,
        RUN       = 3'd5
    } state_t;

    state_t      state, state_nx;
    logic [15:0] cnt, cnt_nx;
    logic        cke_nx;
    logic [2:0]  cmd_nx;
    logic [12:0] addr_nx;
    logic        init_done_nx;
    logic        ref_req_nx;
    logic        ref_miss_nx;
    logic        expire;

    // A delay ends on the edge where the counter would reach zero; a zero
    // count is treated the same so an out-of-range value cannot stall.
    assign expire = (cnt <= 16'd1);

    // State, delay counter and all outputs are registered here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= WAIT_PWR;
            cnt       <= CNT_PWR;
            cke       <= 1'b0;
            cmd       <= CMD_NOP;
            addr      <= 13'd0;
            init_done <= 1'b0;
            ref_req   <= 1'b0;
            ref_miss  <= 1'b0;
        end else begin
            state     <= state_nx;
            cnt       <= cnt_nx;
            cke       <= cke_nx;
            cmd       <= cmd_nx;
            addr      <= addr_nx;
            init_done <= init_done_nx;
            ref_req   <= ref_req_nx;
            ref_miss  <= ref_miss_nx;
        end
    end

    // Next-state and next-output decode; commands are single-cycle, NOP otherwise.
    always_comb begin
        state_nx     = state;
        cnt_nx       = cnt - 16'd1;
        cke_nx       = cke;
        cmd_nx       = CMD_NOP;
        addr_nx      = addr;
        init_done_nx = init_done;
        ref_req_nx   = ref_req;
        ref_miss_nx  = 1'b0;
        case (state)
            WAIT_PWR: begin
                if (expire) begin
                    cke_nx   = 1'b1;
                    cmd_nx   = CMD_PRE;
                    addr_nx  = 13'h0400;
                    cnt_nx   = CNT_RP;
                    state_nx = WAIT_RP;
                end
            end
            WAIT_RP: begin
                if (expire) begin
                    cmd_nx   = CMD_AREF;
                    addr_nx  = 13'd0;
                    cnt_nx   = CNT_RFC;
                    state_nx = WAIT_RFC1;
                end
            end
            WAIT_RFC1: begin
                if (expire) begin
                    cmd_nx   = CMD_AREF;
                    cnt_nx   = CNT_RFC;
                    state_nx = WAIT_RFC2;
                end
            end
            WAIT_RFC2: begin
                if (expire) begin
                    cmd_nx   = CMD_LMR;
                    addr_nx  = MODE_VAL;
                    cnt_nx   = CNT_MRD;
                    state_nx = WAIT_MRD;
                end
            end
            WAIT_MRD: begin
                if (expire) begin
                    init_done_nx = 1'b1;
                    addr_nx      = 13'd0;
                    cnt_nx       = CNT_REF;
                    state_nx     = RUN;
                end
            end
            RUN: begin
                if (expire) begin
                    // A new interval always wins over a coincident ack.
                    cnt_nx      = CNT_REF;
                    ref_req_nx  = 1'b1;
                    ref_miss_nx = ref_req && !ref_ack;
                end else if (ref_ack) begin
                    ref_req_nx = 1'b0;
                end
            end
            default: begin
                state_nx     = WAIT_PWR;
                cnt_nx       = CNT_PWR;
                cke_nx       = 1'b0;
                addr_nx      = 13'd0;
                init_done_nx = 1'b0;
                ref_req_nx   = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_ram_init_seq.sv
// Bench for ram_init_seq with short timing parameters.
module tb_ram_init_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cke;
    logic [2:0]  cmd;
    logic [12:0] addr;
    logic        init_done;
    logic        ref_req;
    logic        ref_ack = 1'b0;
    logic        ref_miss;

    int checks = 0;
    int failures = 0;
    int edge_n = 0;

    ram_init_seq #(
        .PWR_WAIT(10), .T_RP(2), .T_RFC(4), .T_MRD(2),
        .REF_INTERVAL(50), .MODE_VAL(13'h0022)
    ) dut (
        .clk(clk), .rst_n(rst_n), .cke(cke), .cmd(cmd), .addr(addr),
        .init_done(init_done), .ref_req(ref_req), .ref_ack(ref_ack),
        .ref_miss(ref_miss)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          first;
        int          last;
        logic        cke;
        logic [2:0]  cmd;
        logic [12:0] addr;
        logic        init;
    } seg_t;

    seg_t init_tbl[11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s edge=%0d actual=%0h expected=%0h", name, edge_n, act, exp);
        end
    endtask

    // advance one rising edge, then sample on the falling edge
    task automatic step();
        @(posedge clk);
        if (rst_n) edge_n++;
        @(negedge clk);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_cke"}, 32'(cke), 32'd0);
        chk({tag, "_cmd"}, 32'(cmd), 32'h7);
        chk({tag, "_addr"}, 32'(addr), 32'd0);
        chk({tag, "_init"}, 32'(init_done), 32'd0);
        chk({tag, "_req"}, 32'(ref_req), 32'd0);
        chk({tag, "_miss"}, 32'(ref_miss), 32'd0);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n   = 1'b0;
        ref_ack = 1'b0;
        #1;
        chk_reset_vals("rst");
        repeat (3) @(negedge clk);
        edge_n = 0;
        rst_n  = 1'b1;
    endtask

    // walk the init table up to edge 'upto'; ack pulses on edges 5 and 14
    task automatic run_init(input int upto);
        for (int s = 0; s < 11; s++) begin
            for (int e = init_tbl[s].first; e <= init_tbl[s].last; e++) begin
                if (e > upto) return;
                ref_ack = (e == 5 || e == 14);
                step();
                chk("init_cke", 32'(cke), 32'(init_tbl[s].cke));
                chk("init_cmd", 32'(cmd), 32'(init_tbl[s].cmd));
                chk("init_addr", 32'(addr), 32'(init_tbl[s].addr));
                chk("init_done", 32'(init_done), 32'(init_tbl[s].init));
                chk("init_req", 32'(ref_req), 32'd0);
            end
        end
        ref_ack = 1'b0;
    endtask

    // RUN phase: expiry edges are 72, 122, 172; ack asserted on listed edges
    task automatic run_refresh(input string tag, input int acks[$], input int last);
        logic exp_req = 1'b0;
        logic exp_miss;
        bit   exp_x, a;
        for (int e = 25; e <= last; e++) begin
            a = 0;
            foreach (acks[i]) if (acks[i] == e) a = 1;
            ref_ack = a;
            step();
            exp_x = (e >= 72) && ((e - 72) % 50 == 0);
            exp_miss = 1'b0;
            if (exp_x) begin
                exp_miss = exp_req && !a;
                exp_req  = 1'b1;
            end else if (a) begin
                exp_req = 1'b0;
            end
            chk({tag, "_req"}, 32'(ref_req), 32'(exp_req));
            chk({tag, "_miss"}, 32'(ref_miss), 32'(exp_miss));
            chk({tag, "_cmd"}, 32'(cmd), 32'h7);
            chk({tag, "_cke"}, 32'(cke), 32'd1);
            chk({tag, "_init"}, 32'(init_done), 32'd1);
        end
        ref_ack = 1'b0;
    endtask

    initial begin
        init_tbl[0]  = '{1, 9, 1'b0, 3'b111, 13'h000, 1'b0};
        init_tbl[1]  = '{10, 10, 1'b1, 3'b010, 13'h400, 1'b0};
        init_tbl[2]  = '{11, 11, 1'b1, 3'b111, 13'h400, 1'b0};
        init_tbl[3]  = '{12, 12, 1'b1, 3'b001, 13'h000, 1'b0};
        init_tbl[4]  = '{13, 15, 1'b1, 3'b111, 13'h000, 1'b0};
        init_tbl[5]  = '{16, 16, 1'b1, 3'b001, 13'h000, 1'b0};
        init_tbl[6]  = '{17, 19, 1'b1, 3'b111, 13'h000, 1'b0};
        init_tbl[7]  = '{20, 20, 1'b1, 3'b000, 13'h022, 1'b0};
        init_tbl[8]  = '{21, 21, 1'b1, 3'b111, 13'h022, 1'b0};
        init_tbl[9]  = '{22, 22, 1'b1, 3'b111, 13'h000, 1'b1};
        init_tbl[10] = '{23, 24, 1'b1, 3'b111, 13'h000, 1'b1};

        // acks three cycles after each request, plus a stray ack with ref_req low
        apply_reset();
        run_init(24);
        run_refresh("ack3", '{75, 100, 125, 175}, 180);

        // acks withheld: request stays pending, misses at 122 and 172
        apply_reset();
        run_init(24);
        run_refresh("noack", '{}, 180);

        // ack coincides with expiry at 122: request re-arms, no miss there
        apply_reset();
        run_init(24);
        run_refresh("coinc", '{122}, 130);

        // reset between the two refreshes, then the full sequence again
        apply_reset();
        run_init(14);
        rst_n = 1'b0;
        #1;
        chk_reset_vals("midrst");
        repeat (3) @(negedge clk);
        edge_n = 0;
        rst_n  = 1'b1;
        run_init(24);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
